sequenciador_frase: RTL and testbench

Parametrised multi-phrase text sequencer for the game's character display path. It holds several fixed phrases in an internal ROM, selects one on command and streams its characters one at a time to the display driver. Characters are paced by an external `tick` and delivered over a valid/ready handshake, in single-shot or looping mode. It sits between the game control FSM (start, stop, phrase select) and the character display driver.

---
 rtl/frase_pkg.sv | 68 ++++++
 rtl/rom_frases.sv | 20 ++
 rtl/sequenciador_frase.sv | 118 +++++++++++
 tb/tb_sequenciador_frase.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/frase_pkg.sv
// Phrase sequencer shared definitions: character codes, FSM states
// and the fixed phrase table read by rom_frases.
package frase_pkg;

    localparam logic [4:0] BRANCO = 5'h00;
    localparam logic [4:0] A = 5'h01;
    localparam logic [4:0] B = 5'h02;
    localparam logic [4:0] C = 5'h03;
    localparam logic [4:0] D = 5'h04;
    localparam logic [4:0] E = 5'h05;
    localparam logic [4:0] F = 5'h06;
    localparam logic [4:0] G = 5'h07;
    localparam logic [4:0] H = 5'h08;
    localparam logic [4:0] I = 5'h09;
    localparam logic [4:0] J = 5'h0A;
    localparam logic [4:0] K = 5'h0B;
    localparam logic [4:0] L = 5'h0C;
    localparam logic [4:0] M = 5'h0D;
    localparam logic [4:0] N = 5'h0E;
    localparam logic [4:0] O = 5'h0F;
    localparam logic [4:0] P = 5'h10;
    localparam logic [4:0] Q = 5'h11;
    localparam logic [4:0] R = 5'h12;
    localparam logic [4:0] S = 5'h13;
    localparam logic [4:0] T = 5'h14;
    localparam logic [4:0] U = 5'h15;
    localparam logic [4:0] V = 5'h16;
    localparam logic [4:0] W = 5'h17;
    localparam logic [4:0] X = 5'h18;
    localparam logic [4:0] Y = 5'h19;
    localparam logic [4:0] Z = 5'h1A;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        LE      = 3'd1,
        CARREGA = 3'd2,
        ESPERA  = 3'd3,
        ENVIA   = 3'd4,
        FIM     = 3'd5
    } estado_t;

    localparam int N_FRASES_ROM = 4;
    localparam int FRASE_LEN [0:N_FRASES_ROM-1] = '{18, 3, 0, 0};

    localparam logic [4:0] FRASE0 [0:17] = '{
        E, S, C, O, L, H, A, BRANCO, U, M, A, BRANCO,
        M, U, S, I, C, A
    };

    localparam logic [4:0] FRASE1 [0:2] = '{F, I, M};

    function automatic int frase_len(input int f);
        int len;
        len = 0;
        if (f >= 0 && f < N_FRASES_ROM) len = FRASE_LEN[f];
        return len;
    endfunction

    // Anything outside a defined phrase reads back as blank.
    function automatic logic [7:0] frase_char(input int f, input int i);
        logic [7:0] c;
        c = 8'h00;
        if (f == 0 && i >= 0 && i < FRASE_LEN[0]) c = {3'b000, FRASE0[i]};
        if (f == 1 && i >= 0 && i < FRASE_LEN[1]) c = {3'b000, FRASE1[i]};
        return c;
    endfunction

endpackage

// File: rtl/rom_frases.sv
// Synchronous-read phrase ROM addressed by {phrase, index};
// data appears one cycle after the address.
module rom_frases
    import frase_pkg::*;
#(
    parameter int CHAR_W = 5,
    parameter int ADDR_W = 5,
    parameter int SEL_W  = 2
) (
    input  logic              clock,
    input  logic [SEL_W-1:0]  frase,
    input  logic [ADDR_W-1:0] idx,
    output logic [CHAR_W-1:0] dado
);

    always_ff @(posedge clock) begin
        dado <= CHAR_W'(frase_char(int'(frase), int'(idx)));
    end

endmodule

// File: rtl/sequenciador_frase.sv
// Streams a selected ROM phrase to the display driver, one character
// per tick, over a valid/ready handshake in single-shot or loop mode.
module sequenciador_frase
    import frase_pkg::*;
#(
    parameter int CHAR_W   = 5,
    parameter int ADDR_W   = 5,
    parameter int N_FRASES = 4,
    parameter int SEL_W    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              parar,
    input  logic [SEL_W-1:0]  frase_sel,
    input  logic              modo,
    input  logic              tick,
    input  logic              char_pronto,
    output logic              char_valido,
    output logic [CHAR_W-1:0] char_dado,
    output logic [ADDR_W-1:0] char_indice,
    output logic              ocupado,
    output logic              fim
);

    localparam int LEN_W   = ADDR_W + 1;
    localparam int MAX_LEN = 2 ** ADDR_W;

    estado_t           estado;
    logic [SEL_W-1:0]  frase_q;
    logic              modo_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] idx;
    logic [CHAR_W-1:0] dado_q;
    logic [CHAR_W-1:0] rom_dado;

    logic              sel_ok;
    logic              ultimo;
    logic [LEN_W-1:0]  len_sel;
    int                len_int;

    rom_frases #(
        .CHAR_W (CHAR_W),
        .ADDR_W (ADDR_W),
        .SEL_W  (SEL_W)
    ) u_rom (
        .clock (clock),
        .frase (frase_q),
        .idx   (idx),
        .dado  (rom_dado)
    );

    assign sel_ok = int'(frase_sel) < N_FRASES;

    // Phrase length can never exceed what the index register can address.
    always_comb begin
        len_int = frase_len(int'(frase_sel));
        if (len_int > MAX_LEN) len_int = MAX_LEN;
        len_sel = LEN_W'(len_int);
    end

    assign ultimo = ({1'b0, idx} == (len_q - LEN_W'(1)));

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= OCIOSO;
            frase_q <= '0;
            modo_q  <= 1'b0;
            len_q   <= '0;
            idx     <= '0;
            dado_q  <= '0;
        end else if (parar) begin
            estado <= OCIOSO;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (iniciar && sel_ok) begin
                        frase_q <= frase_sel;
                        modo_q  <= modo;
                        len_q   <= len_sel;
                        idx     <= '0;
                        estado  <= (len_sel == '0) ? FIM : LE;
                    end
                end
                LE: estado <= CARREGA;
                CARREGA: begin
                    dado_q <= rom_dado;
                    estado <= ESPERA;
                end
                ESPERA: begin
                    if (tick) estado <= ENVIA;
                end
                ENVIA: begin
                    if (char_pronto) begin
                        if (!ultimo) begin
                            idx    <= idx + ADDR_W'(1);
                            estado <= LE;
                        end else if (modo_q) begin
                            idx    <= '0;
                            estado <= LE;
                        end else begin
                            estado <= FIM;
                        end
                    end
                end
                FIM: estado <= OCIOSO;
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign char_valido = (estado == ENVIA);
    assign char_dado   = dado_q;
    assign char_indice = idx;
    assign ocupado     = (estado != OCIOSO);
    assign fim         = (estado == FIM);

endmodule

// File: tb/tb_sequenciador_frase.sv
// Directed bench for sequenciador_frase: playback, looping, abort,
// empty phrase, ignored commands and mid-stream reset.
module tb_sequenciador_frase;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic       parar = 1'b0;
    logic [1:0] frase_sel = 2'd0;
    logic       modo = 1'b0;
    logic       tick = 1'b0;
    logic       char_pronto = 1'b0;
    logic       char_valido;
    logic [4:0] char_dado;
    logic [4:0] char_indice;
    logic       ocupado;
    logic       fim;

    int errors = 0;
    int checks = 0;
    int fim_cnt = 0;
    int base;

    logic [4:0] f0 [0:17] = '{
        5'h05, 5'h13, 5'h03, 5'h0F, 5'h0C, 5'h08, 5'h01, 5'h00, 5'h15,
        5'h0D, 5'h01, 5'h00, 5'h0D, 5'h15, 5'h13, 5'h09, 5'h03, 5'h01
    };
    logic [4:0] f1 [0:2] = '{5'h06, 5'h09, 5'h0D};

    sequenciador_frase dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .parar       (parar),
        .frase_sel   (frase_sel),
        .modo        (modo),
        .tick        (tick),
        .char_pronto (char_pronto),
        .char_valido (char_valido),
        .char_dado   (char_dado),
        .char_indice (char_indice),
        .ocupado     (ocupado),
        .fim         (fim)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (fim) fim_cnt++;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valido"}, 32'(char_valido), 0);
        chk({tag, "_ocupado"}, 32'(ocupado), 0);
        chk({tag, "_fim"}, 32'(fim), 0);
    endtask

    initial begin
        // reset
        step();
        chk_idle("rst");
        chk("rst_dado", 32'(char_dado), 0);
        chk("rst_indice", 32'(char_indice), 0);
        reset = 1'b0;
        step();

        // phrase 1, single-shot, tick and ready held high
        base = fim_cnt;
        tick = 1'b1;
        char_pronto = 1'b1;
        frase_sel = 2'd1;
        modo = 1'b0;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("p1_ocupado", 32'(ocupado), 1);
        chk("p1_valido_le", 32'(char_valido), 0);
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("p1_valido%0d", k), 32'(char_valido), 1);
            chk($sformatf("p1_dado%0d", k), 32'(char_dado), 32'(f1[k]));
            chk($sformatf("p1_indice%0d", k), 32'(char_indice), k);
            if (k < 2) repeat (4) step();
        end
        step();
        chk("p1_fim", 32'(fim), 1);
        chk("p1_ocupado_fim", 32'(ocupado), 1);
        step();
        chk_idle("p1_end");
        chk("p1_fim_count", fim_cnt - base, 1);

        // phrase 0, loop mode, ready withheld then released
        base = fim_cnt;
        char_pronto = 1'b0;
        frase_sel = 2'd0;
        modo = 1'b1;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        repeat (3) step();
        chk("p0_valido0", 32'(char_valido), 1);
        chk("p0_dado0", 32'(char_dado), 32'h05);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("p0_hold_valido%0d", c), 32'(char_valido), 1);
            chk($sformatf("p0_hold_dado%0d", c), 32'(char_dado), 32'h05);
            chk($sformatf("p0_hold_indice%0d", c), 32'(char_indice), 0);
        end
        char_pronto = 1'b1;
        for (int k = 1; k < 18; k++) begin
            repeat (4) step();
            chk($sformatf("p0_dado%0d", k), 32'(char_dado), 32'(f0[k]));
            chk($sformatf("p0_indice%0d", k), 32'(char_indice), k);
        end
        repeat (4) step();
        chk("p0_wrap_valido", 32'(char_valido), 1);
        chk("p0_wrap_dado", 32'(char_dado), 32'h05);
        chk("p0_wrap_indice", 32'(char_indice), 0);
        chk("p0_wrap_nofim", fim_cnt - base, 0);
        repeat (16) step();
        chk("p0_idx4_valido", 32'(char_valido), 1);
        chk("p0_idx4_indice", 32'(char_indice), 4);
        chk("p0_idx4_dado", 32'(char_dado), 32'(f0[4]));

        // abort in ENVIA with simultaneous start and ready
        parar = 1'b1;
        iniciar = 1'b1;
        frase_sel = 2'd1;
        modo = 1'b0;
        step();
        parar = 1'b0;
        iniciar = 1'b0;
        chk_idle("parar");
        step();
        chk("parar_still_idle", 32'(ocupado), 0);
        chk("parar_nofim", fim_cnt - base, 0);

        // empty phrase
        base = fim_cnt;
        frase_sel = 2'd2;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("p2_fim", 32'(fim), 1);
        chk("p2_valido", 32'(char_valido), 0);
        step();
        chk_idle("p2_end");
        chk("p2_fim_count", fim_cnt - base, 1);

        // restart ignored while busy; ticks before ESPERA dropped
        tick = 1'b0;
        char_pronto = 1'b0;
        frase_sel = 2'd0;
        iniciar = 1'b1;
        step();
        chk("ign_ocupado", 32'(ocupado), 1);
        tick = 1'b1;
        frase_sel = 2'd1;
        step();
        step();
        tick = 1'b0;
        iniciar = 1'b0;
        step();
        chk("ign_tick_drop", 32'(char_valido), 0);
        step();
        chk("ign_tick_wait", 32'(char_valido), 0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("ign_valido", 32'(char_valido), 1);
        chk("ign_dado", 32'(char_dado), 32'h05);
        chk("ign_indice", 32'(char_indice), 0);
        char_pronto = 1'b1;
        step();
        char_pronto = 1'b0;
        chk("ign_le_valido", 32'(char_valido), 0);
        chk("ign_le_indice", 32'(char_indice), 1);
        tick = 1'b1;
        repeat (3) step();
        chk("mid_valido", 32'(char_valido), 1);
        chk("mid_dado", 32'(char_dado), 32'h13);

        // reset mid-stream
        reset = 1'b1;
        step();
        reset = 1'b0;
        tick = 1'b0;
        chk_idle("mid_rst");
        chk("mid_rst_dado", 32'(char_dado), 0);
        chk("mid_rst_indice", 32'(char_indice), 0);
        step();
        chk("mid_rst_stay", 32'(ocupado), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
